// File: rtl/pri_idx_64b.sv
// rtl/pri_idx_64b.sv - sequential set-bit scanner emitting binary indices of a 64-bit mask
// Optional remaining-beat counter cnt_o is built when PRI_IDX_64B_CNT_EN is defined.
module pri_idx_64b #(
    parameter logic MSB_FIRST = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [5:0]  out_idx_o,
    output logic        out_last_o,
    output logic        busy_o
`ifdef PRI_IDX_64B_CNT_EN
    ,
    output logic [6:0]  cnt_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t      state;
    logic [63:0] mask_r;
    logic [5:0]  sel_idx;
    logic        single_bit;
    logic        scan;
    logic        out_fire;
    logic        in_fire;
    logic        load;

    // The last match in loop order wins, so the loop direction picks the end of the mask.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 64; i++) begin
                if (mask_r[i]) sel_idx = 6'(i);
            end
        end else begin
            for (int i = 63; i >= 0; i--) begin
                if (mask_r[i]) sel_idx = 6'(i);
            end
        end
    end

    always_comb begin
        scan        = (state == SCAN);
        single_bit  = (mask_r != 64'd0) && ((mask_r & (mask_r - 64'd1)) == 64'd0);
        out_valid_o = scan;
        out_idx_o   = scan ? sel_idx : 6'd0;
        out_last_o  = scan & single_bit;
        busy_o      = scan;
        out_fire    = out_valid_o & out_ready_i;
        in_ready_o  = ~flush_i & (~scan | (out_fire & out_last_o));
        in_fire     = in_valid_i & in_ready_o;
        load        = in_fire & (in_data_i != 64'd0);
    end

    // A load can only coincide with idle or the final beat, so it may take precedence here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            mask_r <= 64'd0;
        end else if (flush_i) begin
            state  <= IDLE;
            mask_r <= 64'd0;
        end else if (load) begin
            state  <= SCAN;
            mask_r <= in_data_i;
        end else if (out_fire) begin
            if (out_last_o) begin
                state  <= IDLE;
                mask_r <= 64'd0;
            end else begin
                mask_r <= mask_r & ~(64'd1 << sel_idx);
            end
        end
    end

`ifdef PRI_IDX_64B_CNT_EN
    function automatic logic [6:0] popcount(input logic [63:0] d);
        logic [6:0] sum;
        sum = '0;
        for (int i = 0; i < 64; i++) begin
            sum = sum + 7'(d[i]);
        end
        return sum;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= 7'd0;
        end else if (flush_i) begin
            cnt_o <= 7'd0;
        end else if (load) begin
            cnt_o <= popcount(in_data_i);
        end else if (out_fire) begin
            cnt_o <= out_last_o ? 7'd0 : cnt_o - 7'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pri_idx_64b.sv
// tb/tb_pri_idx_64b.sv - self-checking bench for pri_idx_64b, both scan orders side by side
module tb_pri_idx_64b;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        in_ready_l, out_valid_l, last_l, busy_l;
    logic [5:0]  idx_l;
    logic        in_ready_m, out_valid_m, last_m, busy_m;
    logic [5:0]  idx_m;
`ifdef PRI_IDX_64B_CNT_EN
    logic [6:0]  cnt_l, cnt_m;
`endif

    int checks = 0;
    int errors = 0;

    pri_idx_64b #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_l), .in_data_i(in_data),
        .out_valid_o(out_valid_l), .out_ready_i(out_ready), .out_idx_o(idx_l),
        .out_last_o(last_l), .busy_o(busy_l)
`ifdef PRI_IDX_64B_CNT_EN
        , .cnt_o(cnt_l)
`endif
    );

    pri_idx_64b #(.MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_m), .in_data_i(in_data),
        .out_valid_o(out_valid_m), .out_ready_i(out_ready), .out_idx_o(idx_m),
        .out_last_o(last_m), .busy_o(busy_m)
`ifdef PRI_IDX_64B_CNT_EN
        , .cnt_o(cnt_m)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    // k-th set bit of m in emission order, -1 if absent
    function automatic int nth_idx(input logic [63:0] m, input int k, input bit msb);
        int c;
        c = 0;
        for (int j = 0; j < 64; j++) begin
            int b;
            b = msb ? 63 - j : j;
            if (m[b]) begin
                if (c == k) return b;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic logic [63:0] gen_mask();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'd1 << $urandom_range(0, 63);
            2:       return {$urandom, $urandom};
            3:       return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: return {$urandom, $urandom} | {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_reset;
        logic [9:0] rst_vec;
        rst_vec = {1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
        checks++;
        if ({in_ready_l, out_valid_l, idx_l, last_l, busy_l} !== rst_vec ||
            {in_ready_m, out_valid_m, idx_m, last_m, busy_m} !== rst_vec) begin
            errors++;
            $display("FAIL reset_values: lsb=%b msb=%b expected %b",
                     {in_ready_l, out_valid_l, idx_l, last_l, busy_l},
                     {in_ready_m, out_valid_m, idx_m, last_m, busy_m}, rst_vec);
        end
`ifdef PRI_IDX_64B_CNT_EN
        checks++;
        if (cnt_l !== 7'd0 || cnt_m !== 7'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0", cnt_l, cnt_m);
        end
`endif
        rst = 1'b0;
        tick;
        drive(1, 64'hFF, 1, 0);
        tick;
        drive(0, 64'h0, 1, 0);
        checks++;
        if (out_valid_l !== 1'b1 || idx_l !== 6'd0 || idx_m !== 6'd7) begin
            errors++;
            $display("FAIL reset_pre_scan: valid=%b idx=%0d/%0d expected 1 0/7", out_valid_l, idx_l, idx_m);
        end
        tick;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_l, out_valid_l, idx_l, last_l, busy_l} !== rst_vec ||
            {in_ready_m, out_valid_m, idx_m, last_m, busy_m} !== rst_vec) begin
            errors++;
            $display("FAIL reset_async_mid_scan: lsb=%b msb=%b expected %b",
                     {in_ready_l, out_valid_l, idx_l, last_l, busy_l},
                     {in_ready_m, out_valid_m, idx_m, last_m, busy_m}, rst_vec);
        end
        tick;
        checks++;
        if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1 || busy_l !== 1'b0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_edge: valid=%b ready=%b busy=%b/%b expected 0 1 0/0",
                     out_valid_l, in_ready_l, busy_l, busy_m);
        end
`ifdef PRI_IDX_64B_CNT_EN
        checks++;
        if (cnt_l !== 7'd0) begin
            errors++;
            $display("FAIL reset_cnt_mid_scan: got %0d expected 0", cnt_l);
        end
`endif
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic_scan;
        logic [63:0] m;
        m = 64'h8000_0000_0000_0011;
        drive(1, m, 1, 0);
        checks++;
        if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: ready=%b valid=%b expected 1 0", in_ready_l, out_valid_l);
        end
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(0, 64'h0, 1, 0);
            checks++;
            if (out_valid_l !== 1'b1 || idx_l !== 6'(nth_idx(m, k, 0)) || last_l !== (k == 2)) begin
                errors++;
                $display("FAIL basic_lsb beat %0d: valid=%b idx=%0d last=%b expected 1 %0d %b",
                         k, out_valid_l, idx_l, last_l, nth_idx(m, k, 0), k == 2);
            end
            checks++;
            if (out_valid_m !== 1'b1 || idx_m !== 6'(nth_idx(m, k, 1)) || last_m !== (k == 2)) begin
                errors++;
                $display("FAIL basic_msb beat %0d: valid=%b idx=%0d last=%b expected 1 %0d %b",
                         k, out_valid_m, idx_m, last_m, nth_idx(m, k, 1), k == 2);
            end
`ifdef PRI_IDX_64B_CNT_EN
            checks++;
            if (cnt_l !== 7'(3 - k)) begin
                errors++;
                $display("FAIL basic_cnt beat %0d: got %0d expected %0d", k, cnt_l, 3 - k);
            end
`endif
            tick;
        end
        drive(0, 64'h0, 1, 0);
        checks++;
        if (out_valid_l !== 1'b0 || idx_l !== 6'd0 || last_l !== 1'b0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b idx=%0d last=%b busy=%b expected 0 0 0 0",
                     out_valid_l, idx_l, last_l, busy_m);
        end
    endtask

    task automatic test_backpressure;
        drive(1, 64'h6, 0, 0);
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1, 64'h1, 0, 0);
            checks++;
            if (out_valid_l !== 1'b1 || idx_l !== 6'd1 || last_l !== 1'b0 || in_ready_l !== 1'b0 ||
                idx_m !== 6'd2) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: valid=%b idx=%0d/%0d last=%b ready=%b expected 1 1/2 0 0",
                         k, out_valid_l, idx_l, idx_m, last_l, in_ready_l);
            end
            tick;
        end
        drive(0, 64'h0, 1, 0);
        checks++;
        if (idx_l !== 6'd1 || last_l !== 1'b0 || in_ready_l !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: idx=%0d last=%b ready=%b expected 1 0 0", idx_l, last_l, in_ready_l);
        end
        tick;
        drive(0, 64'h0, 1, 0);
        checks++;
        if (idx_l !== 6'd2 || last_l !== 1'b1 || in_ready_l !== 1'b1 || idx_m !== 6'd1 || last_m !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_last: idx=%0d/%0d last=%b/%b ready=%b expected 2/1 1/1 1",
                     idx_l, idx_m, last_l, last_m, in_ready_l);
        end
        tick;
        drive(0, 64'h0, 1, 0);
    endtask

    task automatic test_back_to_back;
        int bad;
        drive(1, 64'h1, 1, 0);
        tick;
        drive(1, ~64'd0, 1, 0);
        checks++;
        if (out_valid_l !== 1'b1 || idx_l !== 6'd0 || last_l !== 1'b1 || in_ready_l !== 1'b1 ||
            idx_m !== 6'd0 || last_m !== 1'b1 || in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b idx=%0d/%0d last=%b/%b ready=%b/%b expected 1 0/0 1/1 1/1",
                     out_valid_l, idx_l, idx_m, last_l, last_m, in_ready_l, in_ready_m);
        end
        tick;
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            drive(0, 64'h0, 1, 0);
            checks++;
            if (out_valid_l !== 1'b1 || idx_l !== 6'(nth_idx(~64'd0, k, 0)) || last_l !== (k == 63) ||
                out_valid_m !== 1'b1 || idx_m !== 6'(nth_idx(~64'd0, k, 1)) || last_m !== (k == 63)) begin
                errors++;
                if (bad < 4)
                    $display("FAIL b2b_beat %0d: valid=%b/%b idx=%0d/%0d last=%b/%b expected 1 %0d/%0d %b",
                             k, out_valid_l, out_valid_m, idx_l, idx_m, last_l, last_m,
                             nth_idx(~64'd0, k, 0), nth_idx(~64'd0, k, 1), k == 63);
                bad++;
            end
`ifdef PRI_IDX_64B_CNT_EN
            checks++;
            if (cnt_l !== 7'(64 - k) || cnt_m !== 7'(64 - k)) begin
                errors++;
                $display("FAIL b2b_cnt beat %0d: got %0d/%0d expected %0d", k, cnt_l, cnt_m, 64 - k);
            end
`endif
            tick;
        end
        drive(0, 64'h0, 1, 0);
        checks++;
        if (out_valid_l !== 1'b0 || busy_l !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: valid=%b busy=%b expected 0 0", out_valid_l, busy_l);
        end
    endtask

    task automatic test_zero_and_flush;
        drive(1, 64'h0, 1, 0);
        checks++;
        if (in_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL zero_accept: ready=%b expected 1", in_ready_l);
        end
        tick;
        for (int k = 0; k < 2; k++) begin
            drive(0, 64'h0, 1, 0);
            checks++;
            if (out_valid_l !== 1'b0 || busy_l !== 1'b0 || out_valid_m !== 1'b0) begin
                errors++;
                $display("FAIL zero_no_beat cycle %0d: valid=%b/%b busy=%b expected 0/0 0",
                         k, out_valid_l, out_valid_m, busy_l);
            end
            tick;
        end
        drive(1, 64'h1C, 1, 0);
        tick;
        drive(1, 64'h3, 1, 1);
        checks++;
        if (out_valid_l !== 1'b1 || idx_l !== 6'd2 || in_ready_l !== 1'b0 || in_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: valid=%b idx=%0d ready=%b/%b expected 1 2 0/0",
                     out_valid_l, idx_l, in_ready_l, in_ready_m);
        end
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(0, 64'h0, 1, 0);
            checks++;
            if (out_valid_l !== 1'b0 || busy_l !== 1'b0 || out_valid_m !== 1'b0 || idx_l !== 6'd0) begin
                errors++;
                $display("FAIL flush_after cycle %0d: valid=%b/%b busy=%b idx=%0d expected 0/0 0 0",
                         k, out_valid_l, out_valid_m, busy_l, idx_l);
            end
`ifdef PRI_IDX_64B_CNT_EN
            checks++;
            if (cnt_l !== 7'd0) begin
                errors++;
                $display("FAIL flush_cnt: got %0d expected 0", cnt_l);
            end
`endif
            tick;
        end
    endtask

    task automatic test_random;
        int q_l[$];
        int q_m[$];
        int sent, cyc, bad;
        logic [63:0] d;
        bit v, r, fl, exp_valid, exp_last, exp_rdy;
        sent = 0;
        cyc  = 0;
        bad  = 0;
        d    = gen_mask();
        while ((sent < 40 || q_l.size() > 0) && cyc < 20000) begin
            v  = (sent < 40) && ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 99) == 0);
            drive(v, d, r, fl);
            exp_valid = (q_l.size() > 0);
            exp_last  = (q_l.size() == 1);
            exp_rdy   = !fl && (!exp_valid || (r && exp_last));
            checks++;
            if (out_valid_l !== exp_valid || out_valid_m !== exp_valid ||
                in_ready_l !== exp_rdy || in_ready_m !== exp_rdy) begin
                errors++;
                if (bad < 8)
                    $display("FAIL rand_handshake cyc %0d: valid=%b/%b ready=%b/%b expected %b %b",
                             cyc, out_valid_l, out_valid_m, in_ready_l, in_ready_m, exp_valid, exp_rdy);
                bad++;
            end
            if (exp_valid) begin
                checks++;
                if (idx_l !== 6'(q_l[0]) || idx_m !== 6'(q_m[0]) ||
                    last_l !== exp_last || last_m !== exp_last) begin
                    errors++;
                    if (bad < 8)
                        $display("FAIL rand_beat cyc %0d: idx=%0d/%0d last=%b/%b expected %0d/%0d %b",
                                 cyc, idx_l, idx_m, last_l, last_m, q_l[0], q_m[0], exp_last);
                    bad++;
                end
`ifdef PRI_IDX_64B_CNT_EN
                checks++;
                if (cnt_l !== 7'(q_l.size()) || cnt_m !== 7'(q_m.size())) begin
                    errors++;
                    if (bad < 8)
                        $display("FAIL rand_cnt cyc %0d: got %0d/%0d expected %0d", cyc, cnt_l, cnt_m, q_l.size());
                    bad++;
                end
`endif
            end else begin
                checks++;
                if (idx_l !== 6'd0 || last_l !== 1'b0 || idx_m !== 6'd0 || last_m !== 1'b0) begin
                    errors++;
                    if (bad < 8)
                        $display("FAIL rand_idle_outputs cyc %0d: idx=%0d/%0d last=%b/%b expected 0 0",
                                 cyc, idx_l, idx_m, last_l, last_m);
                    bad++;
                end
            end
            if (fl) begin
                q_l.delete();
                q_m.delete();
            end else begin
                if (exp_valid && r) begin
                    void'(q_l.pop_front());
                    void'(q_m.pop_front());
                end
                if (v && exp_rdy) begin
                    for (int i = 0; i < 64; i++) if (d[i]) q_l.push_back(i);
                    for (int i = 63; i >= 0; i--) if (d[i]) q_m.push_back(i);
                    sent++;
                    d = gen_mask();
                end
            end
            tick;
            cyc++;
        end
        drive(0, 64'h0, 1, 0);
        checks++;
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: sent=%0d pending=%0d after %0d cycles", sent, q_l.size(), cyc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_basic_scan;
        test_backpressure;
        test_back_to_back;
        test_zero_and_flush;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
